// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the image loader.
// The master modport is the loader; the slave modport is the byte source and memory side.
interface imem_loader_if #(
    parameter int INST_WIDTH_LENGTH = 32,
    parameter int PC_WIDTH_LENGTH   = 32
);
    logic                         byte_valid;
    logic [7:0]                   byte_data;
    logic                         byte_ready;
    logic                         mem_we;
    logic [PC_WIDTH_LENGTH-1:0]   mem_addr;
    logic [INST_WIDTH_LENGTH-1:0] mem_wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian byte image into instruction memory,
// holding the core stalled until the last word has been written.
module imem_loader #(
    parameter int                         INST_WIDTH_LENGTH = 32,
    parameter int                         PC_WIDTH_LENGTH   = 32,
    parameter int                         MEM_DEPTH         = 1 << 18,
    parameter logic [PC_WIDTH_LENGTH-1:0] BASE_ADDR         = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    imem_loader_if.master        bus,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    localparam logic [32:0] MAX_WORDS = 33'(MEM_DEPTH);

    state_e                       state_q, state_d;
    logic [1:0]                   lane_q, lane_d;
    logic [31:0]                  word_cnt_q, word_cnt_d;
    logic [31:0]                  n_q, n_d;
    logic [23:0]                  shift_q, shift_d;
    logic                         mem_we_q, mem_we_d;
    logic [PC_WIDTH_LENGTH-1:0]   mem_addr_q, mem_addr_d;
    logic [INST_WIDTH_LENGTH-1:0] mem_wdata_q, mem_wdata_d;

    logic        ready;
    logic        accept;
    logic [31:0] assembled;

    assign ready     = (state_q == S_HDR) || (state_q == S_DATA);
    assign accept    = bus.byte_valid && ready;
    // Newest byte lands on top, so after four bytes the first one sits in [7:0].
    assign assembled = {bus.byte_data, shift_q};

    // NOTE: every _d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        word_cnt_d  = word_cnt_q;
        n_d         = n_q;
        shift_d     = shift_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_HDR;
                    lane_d     = 2'd0;
                    word_cnt_d = 32'd0;
                end
            end

            S_HDR: begin
                if (accept) begin
                    shift_d = assembled[31:8];
                    lane_d  = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        n_d = assembled;
                        if (assembled == 32'd0) begin
                            state_d = S_DONE;
                        end else if ({1'b0, assembled} > MAX_WORDS) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    shift_d = assembled[31:8];
                    lane_d  = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = BASE_ADDR + PC_WIDTH_LENGTH'({word_cnt_q, 2'b00});
                        mem_wdata_d = INST_WIDTH_LENGTH'(assembled);
                        word_cnt_d  = word_cnt_q + 32'd1;
                        if (word_cnt_q == n_q - 32'd1) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lane_q      <= 2'd0;
            word_cnt_q  <= 32'd0;
            n_q         <= 32'd0;
            shift_q     <= 24'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            word_cnt_q  <= word_cnt_d;
            n_q         <= n_d;
            shift_q     <= shift_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.byte_ready = ready;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    // The last word's write pulse lands in the first DONE cycle, so hold covers it.
    assign busy     = ready;
    assign cpu_hold = ready || mem_we_q;
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed-plus-random bench for imem_loader: two instances (base 0 and base FFFFFFFC)
// share one byte stream; writes are compared against a list built from the image words.
module tb_imem_loader;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       bv;
    logic [7:0] bd;

    logic hold0, busy0, done0, err0;
    logic hold1, busy1, done1, err1;

    int total = 0;
    int bad   = 0;

    logic [63:0] got0[$];
    logic [63:0] got1[$];

    always #5 clk = ~clk;

    imem_loader_if #(.INST_WIDTH_LENGTH(32), .PC_WIDTH_LENGTH(32)) bus0 ();
    imem_loader_if #(.INST_WIDTH_LENGTH(32), .PC_WIDTH_LENGTH(32)) bus1 ();

    assign bus0.byte_valid = bv;
    assign bus0.byte_data  = bd;
    assign bus1.byte_valid = bv;
    assign bus1.byte_data  = bd;

    imem_loader #(.BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus0),
        .cpu_hold(hold0), .busy(busy0), .done(done0), .err(err0)
    );

    imem_loader #(.BASE_ADDR(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus1),
        .cpu_hold(hold1), .busy(busy1), .done(done1), .err(err1)
    );

    always @(negedge clk) begin
        if (bus0.mem_we === 1'b1) got0.push_back({bus0.mem_addr, bus0.mem_wdata});
        if (bus1.mem_we === 1'b1) got1.push_back({bus1.mem_addr, bus1.mem_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic bq_t mk_image(input logic [31:0] n, input wq_t w);
        bq_t q;
        for (int i = 0; i < 4; i++) q.push_back(n[8*i +: 8]);
        foreach (w[k]) for (int i = 0; i < 4; i++) q.push_back(w[k][8*i +: 8]);
        return q;
    endfunction

    function automatic wq_t rand_words(input int n);
        wq_t w;
        for (int i = 0; i < n; i++) w.push_back($urandom());
        return w;
    endfunction

    // Entered and left on a falling edge; each byte is held until the loader takes it.
    task automatic send(input bq_t bytes, input bit gappy);
        foreach (bytes[i]) begin
            int  tries = 0;
            bit  taken = 1'b0;
            while (!taken) begin
                bv = 1'b1;
                bd = bytes[i];
                if (gappy) start = ($urandom_range(0, 1) == 1);
                taken = bus0.byte_ready;
                @(negedge clk);
                tries++;
                if (!taken && tries > 8) begin
                    check("send_timeout", 64'd1, 64'd0);
                    bv = 1'b0;
                    start = 1'b0;
                    return;
                end
            end
            if (gappy && i != bytes.size() - 1) begin
                bv    = 1'b0;
                bd    = 8'($urandom());
                start = ($urandom_range(0, 1) == 1);
                @(negedge clk);
            end
            start = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle_bytes(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bv = 1'b1;
            bd = 8'($urandom());
            @(negedge clk);
        end
        bv = 1'b0;
    endtask

    task automatic cmp_writes(input string tag, input wq_t w);
        check($sformatf("%s_cnt0", tag), 64'(got0.size()), 64'(w.size()));
        check($sformatf("%s_cnt1", tag), 64'(got1.size()), 64'(w.size()));
        foreach (w[k]) begin
            if (k < got0.size())
                check($sformatf("%s_w0_%0d", tag, k), got0[k], {32'(4 * k), w[k]});
            if (k < got1.size())
                check($sformatf("%s_w1_%0d", tag, k), got1[k], {32'hFFFF_FFFC + 32'(4 * k), w[k]});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl0"}, 64'({bus0.mem_we, bus0.byte_ready, hold0, busy0, done0, err0}), 64'd0);
        check({tag, "_ctl1"}, 64'({bus1.mem_we, bus1.byte_ready, hold1, busy1, done1, err1}), 64'd0);
        check({tag, "_bus0"}, {bus0.mem_addr, bus0.mem_wdata}, 64'd0);
        check({tag, "_bus1"}, {bus1.mem_addr, bus1.mem_wdata}, 64'd0);
    endtask

    initial begin
        wq_t w;
        bq_t img;
        bq_t part;

        rst_n = 1'b0;
        start = 1'b0;
        bv    = 1'b0;
        bd    = 8'h00;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-word reference image streamed without gaps.
        got0.delete(); got1.delete();
        w = '{32'h0000_0013, 32'h0010_0093};
        pulse_start();
        check("a_start", 64'({busy0, hold0, done0, busy1, hold1}), 64'b11011);
        send(mk_image(32'd2, w), 1'b0);
        bv = 1'b0;
        check("a_last_pulse", 64'({bus0.mem_we, hold0, done0}), 64'b111);
        @(negedge clk);
        check("a_after", 64'({bus0.mem_we, hold0, done0, busy0, bus1.mem_we, hold1}), 64'b001000);
        check("a_hold_val", {bus0.mem_addr, bus0.mem_wdata}, {32'h4, 32'h0010_0093});
        idle_bytes(3);
        check("a_done_sticky", 64'({done0, bus0.byte_ready, busy0}), 64'b100);
        cmp_writes("a", w);

        // Zero-length image finishes straight from the header.
        got0.delete(); got1.delete();
        pulse_start();
        check("b_done_clr", 64'({done0, busy0}), 64'b01);
        send(mk_image(32'd0, '{}), 1'b0);
        bv = 1'b0;
        check("b_done", 64'({bus0.mem_we, done0, hold0, busy0, err0}), 64'b01000);
        @(negedge clk);
        cmp_writes("b", '{});

        // Oversized header is rejected.
        got0.delete(); got1.delete();
        pulse_start();
        send(mk_image(32'h0004_0001, '{}), 1'b0);
        bv = 1'b0;
        check("c_err", 64'({err0, bus0.byte_ready, bus0.mem_we, hold0, busy0, done0}), 64'b100000);
        idle_bytes(3);
        check("c_err_sticky", 64'({err0, err1, bus0.byte_ready}), 64'b110);
        cmp_writes("c", '{});

        // Random image with valid toggling and stray start pulses, then the same image gap-free.
        w = rand_words($urandom_range(3, 6));
        img = mk_image(32'(w.size()), w);
        got0.delete(); got1.delete();
        pulse_start();
        send(img, 1'b1);
        bv = 1'b0;
        start = 1'b0;
        check("d_gappy_last", 64'({bus0.mem_we, done0, hold0}), 64'b111);
        @(negedge clk);
        cmp_writes("d_gappy", w);
        got0.delete(); got1.delete();
        pulse_start();
        send(img, 1'b0);
        bv = 1'b0;
        @(negedge clk);
        check("d_flat_done", 64'({done0, hold0}), 64'b10);
        cmp_writes("d_flat", w);

        // Reset two bytes into word 1, then reload a fresh image.
        w = rand_words(3);
        img = mk_image(32'd3, w);
        for (int i = 0; i < 10; i++) part.push_back(img[i]);
        got0.delete(); got1.delete();
        pulse_start();
        send(part, 1'b0);
        bv = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("e_rst");
        cmp_writes("e_partial", '{w[0]});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("e_idle", 64'({busy0, bus0.byte_ready, done0, err0}), 64'd0);
        w = rand_words(4);
        got0.delete(); got1.delete();
        pulse_start();
        send(mk_image(32'd4, w), 1'b0);
        bv = 1'b0;
        @(negedge clk);
        check("e_done", 64'({done0, done1, hold0}), 64'b110);
        cmp_writes("e_reload", w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
